div_seq_ctrl: RTL and testbench

//  Multi-cycle sequencer for 32-bit restoring division: one shift/subtract/restore step per clock.

---
 rtl/div_pkg.sv | 16 +
 rtl/div_step.sv | 25 ++
 rtl/div_seq_ctrl.sv | 144 ++++++++++++++
 tb/tb_div_seq_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants and state encoding for the sequential restoring divider.
package div_pkg;

    localparam int DIV_DATA_W = 32;
    localparam int DIV_CNT_W  = 6;

    localparam logic [DIV_DATA_W-1:0] DIV0_QUOTIENT = {DIV_DATA_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the {remainder, quotient} pair left and
// try to subtract the divisor from the upper half.
module div_step
    import div_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
) (
    input  logic [2*DATA_W-1:0] a,
    input  logic [DATA_W-1:0]   m,
    output logic [2*DATA_W-1:0] a_next
);

    logic [DATA_W:0] diff_s;

    // Trial subtract one bit wider than the divisor so large unsigned divisors borrow correctly
    always_comb begin
        diff_s = a[2*DATA_W-1:DATA_W-1] - {1'b0, m};
        if (diff_s[DATA_W]) begin
            a_next = {a[2*DATA_W-2:0], 1'b0};
        end else begin
            a_next = {diff_s[DATA_W-1:0], a[DATA_W-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_seq_ctrl.sv
// Multi-cycle signed/unsigned restoring divider sequencer with start/busy/done
// handshake; one iteration per clock, sign fix-up and divide-by-zero in FIX.
module div_seq_ctrl
    import div_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W,
    parameter int CNT_W  = DIV_CNT_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              is_signed,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic              div_zero
);

    localparam logic [DATA_W-1:0] ONE_W    = DATA_W'(1'b1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DATA_W - 1);

    function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] v);
        return ~v + ONE_W;
    endfunction

    div_state_e          state_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [2*DATA_W-1:0] a_r;
    logic [2*DATA_W-1:0] a_next_s;
    logic [DATA_W-1:0]   m_r;
    logic                sign_q_r;
    logic                sign_m_r;
    logic                busy_r;
    logic                done_r;
    logic [DATA_W-1:0]   quotient_r;
    logic [DATA_W-1:0]   remainder_r;
    logic                div_zero_r;

    logic [DATA_W-1:0]   dividend_mag_s;
    logic [DATA_W-1:0]   divisor_mag_s;
    logic [DATA_W-1:0]   fix_q_s;
    logic [DATA_W-1:0]   fix_r_s;
    logic                fix_dz_s;

    div_step #(.DATA_W(DATA_W)) u_step (
        .a      (a_r),
        .m      (m_r),
        .a_next (a_next_s)
    );

    // Operand magnitudes; the most negative value maps onto itself as unsigned
    always_comb begin
        if (is_signed && dividend[DATA_W-1]) begin
            dividend_mag_s = negate(dividend);
        end else begin
            dividend_mag_s = dividend;
        end
        if (is_signed && divisor[DATA_W-1]) begin
            divisor_mag_s = negate(divisor);
        end else begin
            divisor_mag_s = divisor;
        end
    end

    // Result fix-up; a zero magnitude divisor means the divisor itself was zero
    always_comb begin
        if (m_r == '0) begin
            fix_q_s  = DATA_W'(DIV0_QUOTIENT);
            fix_r_s  = sign_q_r ? negate(a_r[DATA_W-1:0]) : a_r[DATA_W-1:0];
            fix_dz_s = 1'b1;
        end else begin
            fix_q_s  = (sign_q_r ^ sign_m_r) ? negate(a_r[DATA_W-1:0]) : a_r[DATA_W-1:0];
            fix_r_s  = sign_q_r ? negate(a_r[2*DATA_W-1:DATA_W]) : a_r[2*DATA_W-1:DATA_W];
            fix_dz_s = 1'b0;
        end
    end

    // Sequencer FSM with datapath registers and registered handshake/results
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            a_r         <= '0;
            m_r         <= '0;
            sign_q_r    <= 1'b0;
            sign_m_r    <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            quotient_r  <= '0;
            remainder_r <= '0;
            div_zero_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        sign_q_r <= is_signed & dividend[DATA_W-1];
                        sign_m_r <= is_signed & divisor[DATA_W-1];
                        a_r      <= {{DATA_W{1'b0}}, dividend_mag_s};
                        m_r      <= divisor_mag_s;
                        cnt_r    <= '0;
                        busy_r   <= 1'b1;
                        state_r  <= (divisor == '0) ? FIX : ITER;
                    end else begin
                        busy_r   <= 1'b0;
                        state_r  <= IDLE;
                    end
                end
                ITER: begin
                    a_r   <= a_next_s;
                    cnt_r <= cnt_r + CNT_W'(1'b1);
                    if (cnt_r == LAST_CNT) begin
                        state_r <= FIX;
                    end else begin
                        state_r <= ITER;
                    end
                end
                FIX: begin
                    quotient_r  <= fix_q_s;
                    remainder_r <= fix_r_s;
                    div_zero_r  <= fix_dz_s;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b1;
                    state_r     <= DONE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign quotient  = quotient_r;
    assign remainder = remainder_r;
    assign div_zero  = div_zero_r;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Scoreboard bench for div_seq_ctrl: expected results are queued at start and
// popped when done pulses; latency is counted in edges after the start edge.
module tb_div_seq_ctrl;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } res_t;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_zero;

    res_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Normal divide: done follows edge E33 (the 34th edge counting E0); busy covers 33 cycles
    localparam int LAT_NORM = 33;
    localparam int LAT_DIV0 = 1;

    div_seq_ctrl #(.DATA_W(32), .CNT_W(6)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic res_t model(input logic [31:0] dd, input logic [31:0] dv, input logic sg);
        res_t m;
        logic signed [31:0] sd;
        logic signed [31:0] sv;
        sd = dd;
        sv = dv;
        if (dv == 32'd0) begin
            m.q = 32'hFFFF_FFFF; m.r = dd; m.dz = 1'b1;
        end else if (sg && dv == 32'hFFFF_FFFF) begin
            m.q = 32'd0 - dd; m.r = 32'd0; m.dz = 1'b0;
        end else if (sg) begin
            m.q = sd / sv; m.r = sd % sv; m.dz = 1'b0;
        end else begin
            m.q = dd / dv; m.r = dd % dv; m.dz = 1'b0;
        end
        return m;
    endfunction

    // Drive one start cycle, queue its expectation, scramble operands afterwards.
    // Returns at the falling edge just after the accepting edge E0.
    task automatic issue(input logic [31:0] dd, input logic [31:0] dv, input logic sg, input res_t e);
        @(negedge clock);
        start = 1'b1; is_signed = sg; dividend = dd; divisor = dv;
        exp_q.push_back(e);
        @(negedge clock);
        start = 1'b0; dividend = $urandom; divisor = $urandom;
        is_signed = 1'($urandom_range(0, 1));
    endtask

    // Count edges until done is seen (bounded); also counts busy-high cycles on the way.
    task automatic wait_done(output int lat, output int busy_n, output bit ok);
        lat = 0; busy_n = 0; ok = 1'b0;
        while (lat < 200) begin
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            if (busy === 1'b1) busy_n++;
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clock);
        n_cmp++;
        if ({busy, done, quotient, remainder, div_zero} !== 67'd0) begin
            n_err++;
            $display("FAIL reset_state: got busy=%b done=%b q=%h r=%h dz=%b want all 0",
                     busy, done, quotient, remainder, div_zero);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_unsigned;
        res_t e; int lat; int bn; bit ok;
        issue(32'd100, 32'd7, 1'b0, '{q: 32'd14, r: 32'd2, dz: 1'b0});
        wait_done(lat, bn, ok);
        e = exp_q.pop_front();
        n_cmp++;
        if (!ok || {quotient, remainder, div_zero} !== e) begin
            n_err++;
            $display("FAIL u100_7: got q=%h r=%h dz=%b want q=%h r=%h dz=%b", quotient, remainder, div_zero, e.q, e.r, e.dz);
        end
        n_cmp++;
        if (lat !== LAT_NORM) begin
            n_err++; $display("FAIL u100_7_latency: got %0d want %0d", lat, LAT_NORM);
        end
        n_cmp++;
        if (bn !== 33) begin
            n_err++; $display("FAIL u100_7_busy_cycles: got %0d want 33", bn);
        end
        @(negedge clock);
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++; $display("FAIL done_pulse_width: got done=%b want 0", done);
        end
    endtask

    task automatic test_signed;
        logic [31:0] dds [2] = '{32'hFFFF_FFF9, 32'd7};
        logic [31:0] dvs [2] = '{32'd2, 32'hFFFF_FFFE};
        res_t        exs [2] = '{'{q: 32'hFFFF_FFFD, r: 32'hFFFF_FFFF, dz: 1'b0},
                                 '{q: 32'hFFFF_FFFD, r: 32'd1, dz: 1'b0}};
        res_t e; int lat; int bn; bit ok;
        for (int i = 0; i < 2; i++) begin
            issue(dds[i], dvs[i], 1'b1, exs[i]);
            wait_done(lat, bn, ok);
            e = exp_q.pop_front();
            n_cmp++;
            if (!ok || {quotient, remainder, div_zero} !== e) begin
                n_err++;
                $display("FAIL signed_%0d: got q=%h r=%h dz=%b want q=%h r=%h dz=%b", i, quotient, remainder, div_zero, e.q, e.r, e.dz);
            end
            n_cmp++;
            if (lat !== LAT_NORM) begin
                n_err++; $display("FAIL signed_%0d_latency: got %0d want %0d", i, lat, LAT_NORM);
            end
        end
    endtask

    task automatic test_div_zero;
        logic [31:0] dds [3] = '{32'd5, 32'hFFFF_FFFB, 32'd9};
        logic [31:0] dvs [3] = '{32'd0, 32'd0, 32'd3};
        logic        sgs [3] = '{1'b0, 1'b1, 1'b0};
        res_t        exs [3] = '{'{q: 32'hFFFF_FFFF, r: 32'd5, dz: 1'b1},
                                 '{q: 32'hFFFF_FFFF, r: 32'hFFFF_FFFB, dz: 1'b1},
                                 '{q: 32'd3, r: 32'd0, dz: 1'b0}};
        int          lats [3] = '{LAT_DIV0, LAT_DIV0, LAT_NORM};
        res_t e; int lat; int bn; bit ok;
        for (int i = 0; i < 3; i++) begin
            issue(dds[i], dvs[i], sgs[i], exs[i]);
            wait_done(lat, bn, ok);
            e = exp_q.pop_front();
            n_cmp++;
            if (!ok || {quotient, remainder, div_zero} !== e) begin
                n_err++;
                $display("FAIL div0_seq_%0d: got q=%h r=%h dz=%b want q=%h r=%h dz=%b", i, quotient, remainder, div_zero, e.q, e.r, e.dz);
            end
            n_cmp++;
            if (lat !== lats[i]) begin
                n_err++; $display("FAIL div0_seq_%0d_latency: got %0d want %0d", i, lat, lats[i]);
            end
        end
    endtask

    task automatic test_edges;
        logic [31:0] dds [2] = '{32'hFFFF_FFFF, 32'h8000_0000};
        logic [31:0] dvs [2] = '{32'h8000_0000, 32'hFFFF_FFFF};
        logic        sgs [2] = '{1'b0, 1'b1};
        res_t        exs [2] = '{'{q: 32'd1, r: 32'h7FFF_FFFF, dz: 1'b0},
                                 '{q: 32'h8000_0000, r: 32'd0, dz: 1'b0}};
        res_t e; int lat; int bn; bit ok;
        for (int i = 0; i < 2; i++) begin
            issue(dds[i], dvs[i], sgs[i], exs[i]);
            wait_done(lat, bn, ok);
            e = exp_q.pop_front();
            n_cmp++;
            if (!ok || {quotient, remainder, div_zero} !== e) begin
                n_err++;
                $display("FAIL edge_%0d: got q=%h r=%h dz=%b want q=%h r=%h dz=%b", i, quotient, remainder, div_zero, e.q, e.r, e.dz);
            end
        end
    endtask

    task automatic test_mid_divide;
        res_t e; int lat; int bn; bit ok; int seen;
        issue(32'd1000, 32'd10, 1'b0, '{q: 32'd100, r: 32'd0, dz: 1'b0});
        repeat (10) @(negedge clock);
        start = 1'b1; dividend = 32'd5; divisor = 32'd1;
        @(negedge clock);
        start = 1'b0;
        wait_done(lat, bn, ok);
        e = exp_q.pop_front();
        n_cmp++;
        if (!ok || {quotient, remainder, div_zero} !== e) begin
            n_err++;
            $display("FAIL mid_start_ignored: got q=%h r=%h dz=%b want q=%h r=%h dz=%b", quotient, remainder, div_zero, e.q, e.r, e.dz);
        end
        n_cmp++;
        if (lat + 11 !== LAT_NORM) begin
            n_err++; $display("FAIL mid_start_latency: got %0d want %0d", lat + 11, LAT_NORM);
        end
        issue(32'd1000, 32'd10, 1'b0, '{q: 32'd100, r: 32'd0, dz: 1'b0});
        repeat (10) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        n_cmp++;
        if ({busy, done, quotient, remainder, div_zero} !== 67'd0) begin
            n_err++;
            $display("FAIL mid_reset_outputs: got busy=%b done=%b q=%h r=%h dz=%b want all 0", busy, done, quotient, remainder, div_zero);
        end
        reset_n = 1'b1;
        exp_q.delete();
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (done !== 1'b0 || busy !== 1'b0) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_err++; $display("FAIL mid_reset_idle: got %0d active cycles want 0", seen);
        end
    endtask

    task automatic test_back_to_back;
        res_t e; int lat; int bn; bit ok;
        @(negedge clock);
        start = 1'b1; is_signed = 1'b0; dividend = 32'd50; divisor = 32'd5;
        exp_q.push_back('{q: 32'd10, r: 32'd0, dz: 1'b0});
        @(negedge clock);
        dividend = 32'd200; divisor = 32'd7;
        exp_q.push_back(model(32'd200, 32'd7, 1'b0));
        wait_done(lat, bn, ok);
        e = exp_q.pop_front();
        n_cmp++;
        if (!ok || {quotient, remainder, div_zero} !== e) begin
            n_err++;
            $display("FAIL b2b_first: got q=%h r=%h dz=%b want q=%h r=%h dz=%b", quotient, remainder, div_zero, e.q, e.r, e.dz);
        end
        n_cmp++;
        if (lat !== LAT_NORM) begin
            n_err++; $display("FAIL b2b_first_latency: got %0d want %0d", lat, LAT_NORM);
        end
        @(negedge clock);
        start = 1'b0;
        n_cmp++;
        if ({done, busy, quotient} !== {1'b0, 1'b1, e.q}) begin
            n_err++;
            $display("FAIL b2b_accept: got done=%b busy=%b q=%h want done=0 busy=1 q=%h", done, busy, quotient, e.q);
        end
        wait_done(lat, bn, ok);
        e = exp_q.pop_front();
        n_cmp++;
        if (!ok || {quotient, remainder, div_zero} !== e) begin
            n_err++;
            $display("FAIL b2b_second: got q=%h r=%h dz=%b want q=%h r=%h dz=%b", quotient, remainder, div_zero, e.q, e.r, e.dz);
        end
        n_cmp++;
        if (lat !== LAT_NORM) begin
            n_err++; $display("FAIL b2b_second_latency: got %0d want %0d", lat, LAT_NORM);
        end
    endtask

    task automatic test_random;
        res_t e; int lat; int bn; bit ok; int want_lat;
        logic [31:0] dd; logic [31:0] dv; logic sg;
        for (int i = 0; i < 8; i++) begin
            dd = $urandom;
            case (i % 4)
                0: dv = 32'($urandom_range(1, 255));
                1: dv = $urandom;
                2: dv = 32'd0;
                default: dv = 32'hFFFF_FFFF;
            endcase
            sg = 1'($urandom_range(0, 1));
            want_lat = (dv == 32'd0) ? LAT_DIV0 : LAT_NORM;
            issue(dd, dv, sg, model(dd, dv, sg));
            wait_done(lat, bn, ok);
            e = exp_q.pop_front();
            n_cmp++;
            if (!ok || {quotient, remainder, div_zero} !== e) begin
                n_err++;
                $display("FAIL rand_%0d %h/%h s=%b: got q=%h r=%h dz=%b want q=%h r=%h dz=%b",
                         i, dd, dv, sg, quotient, remainder, div_zero, e.q, e.r, e.dz);
            end
            n_cmp++;
            if (lat !== want_lat) begin
                n_err++; $display("FAIL rand_%0d_latency: got %0d want %0d", i, lat, want_lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_edges();
        test_mid_divide();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
